// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage controller.
package mem_stage_pkg;

  // Default data/address width of the memory stage.
  localparam int unsigned DATA_W_DEF = 16;

  // Bits that must be zero for an address to be halfword aligned.
  localparam logic [DATA_W_DEF-1:0] ALIGN_MASK = 16'h0001;

  // Controller states: IDLE presents requests, WAIT holds for mem_done.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage : mem_stage_pkg

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter: cleared when a request is accepted, counts while
// waiting for a response, and flags expiry at TIMEOUT-1.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and hold at the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_LAST);

endmodule : mem_timeout_ctr

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues one memory transaction per EX/MEM
// load/store, stalls the upstream pipeline until it completes, checks
// alignment, times out lost responses and gates halt until traffic drains.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              XM_memRead,
  input  logic              XM_memWrite,
  input  logic [DATA_W-1:0] XM_aluOut,
  input  logic [DATA_W-1:0] XM_writeData,
  input  logic              XM_halt,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] M_readData,
  output logic              halt_out,
  output logic              err
);

  localparam logic [DATA_W-1:0] ALIGN_MASK_W = DATA_W'(ALIGN_MASK);

  mem_state_e        state_q;
  mem_state_e        state_d;
  logic              wr_q;
  logic              wr_d;
  logic              err_q;
  logic              err_d;

  logic              access_s;
  logic              misalign_s;
  logic              en_s;
  logic              stall_s;
  logic              halt_s;
  logic [DATA_W-1:0] rdata_s;
  logic              ctr_clear_s;
  logic              ctr_en_s;
  logic              ctr_expired_s;

  // A store wins when both request bits are set.
  assign access_s   = XM_memRead | XM_memWrite;
  assign misalign_s = |(XM_aluOut & ALIGN_MASK_W);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (ctr_clear_s),
    .enable  (ctr_en_s),
    .expired (ctr_expired_s)
  );

  // Next-state and combinational outputs of the request/wait FSM.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    err_d       = err_q;
    ctr_clear_s = 1'b0;
    ctr_en_s    = 1'b0;
    en_s        = 1'b0;
    stall_s     = 1'b0;
    halt_s      = 1'b0;
    rdata_s     = '0;
    case (state_q)
      ST_IDLE: begin
        if (access_s) begin
          if (misalign_s) begin
            // Misaligned access retires as a no-op and flags the error.
            err_d = 1'b1;
          end else begin
            en_s    = 1'b1;
            stall_s = 1'b1;
            if (!mem_stall) begin
              state_d     = ST_WAIT;
              wr_d        = XM_memWrite;
              ctr_clear_s = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          // Spurious mem_done is ignored here; only halt can retire.
          halt_s = XM_halt;
        end
      end
      ST_WAIT: begin
        if (mem_done) begin
          state_d = ST_IDLE;
          if (!wr_q) begin
            rdata_s = mem_rdata;
          end else begin
            rdata_s = '0;
          end
        end else if (ctr_expired_s) begin
          // Response lost: release the pipeline and flag the error.
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall_s  = 1'b1;
          ctr_en_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, accepted-direction and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced low while reset is asserted.
  assign mem_en     = en_s & rst_n;
  assign mem_wr     = en_s & XM_memWrite & rst_n;
  assign mem_addr   = (en_s && rst_n) ? XM_aluOut : '0;
  assign mem_wdata  = (en_s && rst_n) ? XM_writeData : '0;
  assign stall      = stall_s & rst_n;
  assign M_readData = rst_n ? rdata_s : '0;
  assign halt_out   = halt_s & rst_n;
  assign err        = err_q & rst_n;

endmodule : mem_stage_ctrl
